// File: rtl/inst_mem_loader.sv
// inst_mem_loader: fills instruction memory from a framed byte stream.
// Frame: 4-byte word count N (MSB first), 4*N big-endian payload bytes,
// then one checksum byte equal to the XOR of every payload byte.
// The core is held in reset until a verified image has been written.
module inst_mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 131072
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        cpu_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;        // byte position within the current 4-byte group
  logic [31:0] len_q, len_d;        // word count N
  logic [31:0] wcnt_q, wcnt_d;      // words written so far
  logic [31:0] word_q, word_d;      // word being assembled
  logic [7:0]  csum_q, csum_d;      // running XOR of payload bytes
  logic [31:0] naddr_q, naddr_d;    // address the next completed word goes to
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        we_q, we_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        acc;

  assign byte_ready_o = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
  assign acc          = byte_valid_i && byte_ready_o;

  // Next-state and datapath: one byte is consumed per handshake, write pulses last one cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    wcnt_d    = wcnt_q;
    word_d    = word_q;
    csum_d    = csum_q;
    naddr_d   = naddr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = 1'b0;
    // Registered so it drops one cycle after DONE is entered and rises one after leaving.
    cpu_rst_d = (state_q != DONE);
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_d = LEN;
          cnt_d   = 2'd0;
          len_d   = 32'd0;
          wcnt_d  = 32'd0;
          csum_d  = 8'd0;
          addr_d  = BASE_ADDR;
          naddr_d = BASE_ADDR;
        end
      end
      LEN: begin
        if (acc) begin
          len_d = {len_q[23:0], byte_i};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (len_d > MAX_W)       state_d = ERR;
            else if (len_d == 32'd0) state_d = CSUM;
            else                     state_d = DATA;
          end
        end
      end
      DATA: begin
        if (acc) begin
          word_d = {word_q[23:0], byte_i};
          csum_d = csum_q ^ byte_i;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            we_d    = 1'b1;
            data_d  = word_d;
            addr_d  = naddr_q;
            naddr_d = naddr_q + 32'd4;
            wcnt_d  = wcnt_q + 32'd1;
            if (wcnt_q == len_q - 32'd1) state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (acc) state_d = (byte_i == csum_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; synchronous reset aborts any load in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      len_q     <= 32'd0;
      wcnt_q    <= 32'd0;
      word_q    <= 32'd0;
      csum_q    <= 8'd0;
      naddr_q   <= BASE_ADDR;
      addr_q    <= BASE_ADDR;
      data_q    <= 32'd0;
      we_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      word_q    <= word_d;
      csum_q    <= csum_d;
      naddr_q   <= naddr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  assign mem_we_o   = we_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
  assign cpu_rst_o  = cpu_rst_q;
  assign busy_o     = byte_ready_o;
  assign done_o     = (state_q == DONE);
  assign error_o    = (state_q == ERR);

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: expected writes are queued as frames
// are driven and retired by a monitor that watches the write strobe.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst, start_i, byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o, mem_we_o, cpu_rst_o, busy_o, done_o, error_o;
  logic [31:0] mem_addr_o, mem_data_o;

  inst_mem_loader dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(byte_ready_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  int errors = 0;
  int checks = 0;
  bit rnd    = 0;

  logic [31:0] img [2] = '{32'h3C01_0101, 32'h3421_0020};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Retire expected writes on each strobe; ready must track busy at all times.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("ready_vs_busy", 32'(byte_ready_o), 32'(busy_o));
      if (mem_we_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", mem_addr_o, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", mem_addr_o, e.addr);
          chk("wr_data", mem_data_o, e.data);
        end
      end
    end
  end

  // Offer one byte until it is accepted (bounded); called just after a negedge.
  task automatic send_byte(input logic [7:0] b);
    int  t = 0;
    bit  acc;
    byte_i = b;
    forever begin
      byte_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1 acc = byte_valid_i && byte_ready_o;
      @(posedge clk);
      @(negedge clk);
      if (acc) break;
      t++;
      if (t > 60) begin
        chk("byte_timeout", 32'(t), 32'd0);
        break;
      end
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Full frame for the two-word image with the given checksum; queues writes.
  task automatic load_img(input logic [7:0] cs);
    send_word(32'd2);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{addr: 32'(4 * k), data: img[k]});
      send_word(img[k]);
    end
    send_byte(cs);
  endtask

  function automatic logic [7:0] img_csum();
    logic [7:0] c = 8'h00;
    for (int k = 0; k < 2; k++)
      c = c ^ img[k][31:24] ^ img[k][23:16] ^ img[k][15:8] ^ img[k][7:0];
    return c;
  endfunction

  initial begin
    logic [7:0] good_cs;
    good_cs      = img_csum();
    rst          = 1'b1;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_i       = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_data", mem_data_o, 32'h0);
    chk("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    chk("rst_status", {29'd0, busy_o, done_o, error_o}, 32'd0);
    chk("rst_ready", 32'(byte_ready_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(byte_ready_o), 32'd0);

    // Good two-word load
    pulse_start();
    chk("busy_after_start", 32'(busy_o), 32'd1);
    load_img(good_cs);
    chk("good_done", 32'(done_o), 32'd1);
    chk("good_cpu_rst_lag", 32'(cpu_rst_o), 32'd1);
    @(negedge clk);
    chk("good_cpu_rst_low", 32'(cpu_rst_o), 32'd0);
    chk("good_error", 32'(error_o), 32'd0);
    chk("good_ready_done", 32'(byte_ready_o), 32'd0);
    chk("good_all_written", 32'(exp_q.size()), 32'd0);

    // Bad checksum: both writes still happen, then ERR
    pulse_start();
    load_img(good_cs ^ 8'h21);
    @(negedge clk);
    chk("bad_error", 32'(error_o), 32'd1);
    chk("bad_done", 32'(done_o), 32'd0);
    chk("bad_cpu_rst", 32'(cpu_rst_o), 32'd1);
    chk("bad_all_written", 32'(exp_q.size()), 32'd0);
    pulse_start();
    chk("restart_busy", 32'(busy_o), 32'd1);

    // Oversize length straight from LEN: ERR, no writes
    send_word(32'h0002_0001);
    chk("big_error", 32'(error_o), 32'd1);
    chk("big_ready", 32'(byte_ready_o), 32'd0);
    byte_i = 8'hAA; byte_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    byte_valid_i = 1'b0;
    chk("big_still_err", 32'(error_o), 32'd1);

    // Empty image, good then bad checksum
    pulse_start();
    send_word(32'd0);
    send_byte(8'h00);
    chk("empty_done", 32'(done_o), 32'd1);
    pulse_start();
    send_word(32'd0);
    send_byte(8'h01);
    chk("empty_bad_err", 32'(error_o), 32'd1);

    // Throttled valid during a good load
    rnd = 1;
    pulse_start();
    load_img(good_cs);
    rnd = 0;
    chk("rnd_done", 32'(done_o), 32'd1);
    chk("rnd_all_written", 32'(exp_q.size()), 32'd0);

    // Reset after five payload bytes: first word written, nothing after
    pulse_start();
    send_word(32'd2);
    exp_q.push_back('{addr: 32'h0, data: img[0]});
    send_word(img[0]);
    send_byte(img[1][31:24]);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_ready", 32'(byte_ready_o), 32'd0);
    chk("abort_we", 32'(mem_we_o), 32'd0);
    chk("abort_addr", mem_addr_o, 32'h0);
    chk("abort_data", mem_data_o, 32'h0);
    chk("abort_cpu_rst", 32'(cpu_rst_o), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_idle", {29'd0, busy_o, done_o, error_o}, 32'd0);
    pulse_start();
    load_img(good_cs);
    chk("reload_done", 32'(done_o), 32'd1);
    @(negedge clk);
    chk("reload_cpu_rst", 32'(cpu_rst_o), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
